mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/common_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the memory-arbiter slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package common;

    // Arbiter access states; IDLE must stay the all-zero reset encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCR    = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: time-shares one async SRAM between screen fetch and the CPU, screen first with CPU anti-starvation.
// Latency: ACCESS_CYCLES clk28 cycles per access, back-to-back; cpu_ack pulses the cycle after the last CPU cycle.
// Backpressure: cpu_wait stalls the CPU until cpu_ack; the screen is paced by screen_fetch_allow.
//
// Ports: clk28/rst_n (async active-low); screen_* fetch side; cpu_* request/ack side; sram_* device pins.
// Optional feature: define MEM_ARBITER_ROM_WP_EN to suppress the write strobe for CPU writes with cpu_rom=1.
module mem_arbiter
    import common::*;
#(
    parameter int ACCESS_CYCLES = 3,
    parameter int STARVE_LIMIT  = 2
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        screen_req,
    input  logic [3:0]  screen_base,
    input  logic [14:0] screen_addr,
    output logic        screen_fetch_allow,
    output logic [7:0]  screen_data,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_rom,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_wait,
    output logic [18:0] sram_addr,
    input  logic [7:0]  sram_dq_i,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 2;
    localparam int SW = $clog2(STARVE_LIMIT + 1) > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(ACCESS_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [18:0]   lat_addr;
    logic [7:0]    lat_wdata;
    logic          lat_rom;

    logic last_cyc, arb, cpu_last, cpu_pend, cpu_win, wr_protect;

    always_comb begin
        last_cyc  = (state != IDLE) && (cnt == LAST_CNT);
        arb       = (state == IDLE) || last_cyc;
        cpu_last  = last_cyc && ((state == CPU_RD) || (state == CPU_WR));
        // The request being served (or just acked) is still held high; it must
        // not win a second grant.
        cpu_pend  = cpu_req && !cpu_ack && !cpu_last;
        cpu_win   = cpu_pend && (!screen_req || (starve_cnt == STARVE_MX));

        state_nxt  = state;
        starve_nxt = starve_cnt;
        cnt_nxt    = ((state != IDLE) && !last_cyc) ? cnt + CW'(1) : '0;

        if (arb) begin
            if (cpu_win)
                state_nxt = cpu_wr ? CPU_WR : CPU_RD;
            else if (screen_req)
                state_nxt = SCR;
            else
                state_nxt = IDLE;
        end

        // Screen grants made while the CPU request line is high count toward
        // starvation, including the one issued as a CPU access finishes.
        if (!cpu_req)
            starve_nxt = '0;
        else if (arb && cpu_win)
            starve_nxt = '0;
        else if (arb && screen_req && (starve_cnt != STARVE_MX))
            starve_nxt = starve_cnt + SW'(1);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= 8'h00;
            lat_addr   <= '0;
            lat_wdata  <= 8'h00;
            lat_rom    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            starve_cnt <= starve_nxt;
            cpu_ack    <= cpu_last;
            if (last_cyc && (state == CPU_RD))
                cpu_rdata <= sram_dq_i;
            // Capture address/data at grant so mid-access input changes are ignored.
            if (arb && (state_nxt != IDLE)) begin
                lat_addr  <= cpu_win ? cpu_addr : {screen_base, screen_addr};
                lat_wdata <= cpu_wdata;
                lat_rom   <= cpu_rom;
            end
        end
    end

`ifdef MEM_ARBITER_ROM_WP_EN
    assign wr_protect = lat_rom;
`else
    logic unused_rom;
    assign unused_rom = lat_rom;
    assign wr_protect = 1'b0;
`endif

    // Output decode from registered state only; reset forces IDLE so the pins
    // go inactive asynchronously.
    always_comb begin
        screen_fetch_allow = 1'b0;
        sram_oe_n          = 1'b1;
        sram_we_n          = 1'b1;
        sram_dq_oe         = 1'b0;
        sram_dq_o          = 8'h00;
        sram_addr          = lat_addr;
        case (state)
            SCR: begin
                screen_fetch_allow = 1'b1;
                sram_oe_n          = 1'b0;
            end
            CPU_RD: begin
                sram_oe_n = 1'b0;
            end
            CPU_WR: begin
                sram_dq_o = lat_wdata;
                if (!wr_protect) begin
                    sram_dq_oe = 1'b1;
                    // Strobe excludes first and last cycle for address setup and data hold.
                    sram_we_n  = !((cnt != '0) && (cnt != LAST_CNT));
                end
            end
            default: ;
        endcase
    end

    assign screen_data = sram_dq_i;
    assign cpu_wait    = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic        clk28 = 1'b0;
    logic        rst_n;
    logic        screen_req;
    logic [3:0]  screen_base;
    logic [14:0] screen_addr;
    logic        screen_fetch_allow;
    logic [7:0]  screen_data;
    logic        cpu_req, cpu_wr, cpu_rom;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_wait;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dq_i, sram_dq_o;
    logic        sram_dq_oe, sram_oe_n, sram_we_n;

    int checks = 0;
    int errors = 0;

    always #5 clk28 = ~clk28;

    // SRAM stand-in: data = low address byte XOR E0 (12345 -> A5, 29800 -> E0).
    assign sram_dq_i = sram_addr[7:0] ^ 8'hE0;

    mem_arbiter #(.ACCESS_CYCLES(3), .STARVE_LIMIT(2)) dut (
        .clk28(clk28), .rst_n(rst_n),
        .screen_req(screen_req), .screen_base(screen_base), .screen_addr(screen_addr),
        .screen_fetch_allow(screen_fetch_allow), .screen_data(screen_data),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_rom(cpu_rom), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk28);
            if (sram_oe_n && sram_we_n && !sram_dq_oe && !screen_fetch_allow) break;
        end
        checks++;
        if (!(sram_oe_n && sram_we_n && !sram_dq_oe && !screen_fetch_allow)) begin
            errors++;
            $display("FAIL %s_idle_timeout oe_n=%b we_n=%b dq_oe=%b allow=%b want 1 1 0 0",
                     name, sram_oe_n, sram_we_n, sram_dq_oe, screen_fetch_allow);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; screen_req = 0; screen_base = 0; screen_addr = 0;
        cpu_req = 0; cpu_wr = 0; cpu_rom = 0; cpu_addr = 0; cpu_wdata = 0;
        repeat (2) @(negedge clk28);
        checks++;
        if ({screen_fetch_allow, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, cpu_wait} !== 6'b011000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 011000",
                     {screen_fetch_allow, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, cpu_wait});
        end
        checks++;
        if (cpu_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_rdata got %h want 00", cpu_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk28);
        checks++;
        if (sram_oe_n !== 1'b1 || screen_fetch_allow !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset oe_n=%b allow=%b want 1 0", sram_oe_n, screen_fetch_allow);
        end
    endtask

    task automatic test_screen();
        screen_req = 1; screen_base = 4'h5; screen_addr = 15'h1800;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk28);
            checks++;
            if ({screen_fetch_allow, sram_oe_n, sram_we_n} !== 3'b101 || sram_addr !== 19'h29800) begin
                errors++;
                $display("FAIL screen_cyc%0d allow/oe_n/we_n=%b addr=%h want 101 29800",
                         n, {screen_fetch_allow, sram_oe_n, sram_we_n}, sram_addr);
            end
            checks++;
            if (screen_data !== 8'hE0) begin
                errors++; $display("FAIL screen_data_cyc%0d got %h want e0", n, screen_data);
            end
        end
        screen_req = 0;
        wait_idle("screen");
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h12345;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk28);
            if (n <= 3) begin
                checks++;
                if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== 19'h12345 ||
                    cpu_ack !== 1'b0 || cpu_wait !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_cyc%0d oe_n=%b we_n=%b addr=%h ack=%b wait=%b want 0 1 12345 0 1",
                             n, sram_oe_n, sram_we_n, sram_addr, cpu_ack, cpu_wait);
                end
                if (n == 1) cpu_addr = 19'h00000;
            end else if (n == 4) begin
                checks++;
                if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5 || cpu_wait !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_ack ack=%b rdata=%h wait=%b want 1 a5 0", cpu_ack, cpu_rdata, cpu_wait);
                end
                cpu_req = 0;
            end else begin
                checks++;
                if (cpu_ack !== 1'b0 || sram_oe_n !== 1'b1) begin
                    errors++; $display("FAIL rd_ack_width ack=%b oe_n=%b want 0 1", cpu_ack, sram_oe_n);
                end
            end
        end
    endtask

    // Write with cpu_req dropped mid-access and data changed after grant.
    task automatic test_cpu_write(input logic rom, input logic expect_we);
        int we_low = 0;
        cpu_req = 1; cpu_wr = 1; cpu_rom = rom; cpu_addr = 19'h00042; cpu_wdata = 8'h3C;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk28);
            if (!sram_we_n) we_low++;
            checks++;
            if (!sram_we_n && !sram_oe_n) begin
                errors++; $display("FAIL wr_oe_we_overlap cyc%0d both low", n);
            end
            if (n <= 3) begin
                checks++;
                if (sram_dq_oe !== expect_we || sram_we_n !== !(expect_we && n == 2) ||
                    (expect_we && sram_dq_o !== 8'h3C)) begin
                    errors++;
                    $display("FAIL wr_rom%0b_cyc%0d dq_oe=%b we_n=%b dq_o=%h want %b %b 3c",
                             rom, n, sram_dq_oe, sram_we_n, sram_dq_o, expect_we, !(expect_we && n == 2));
                end
                if (n == 1) cpu_wdata = 8'hFF;
                if (n == 2) cpu_req = 0;
            end else if (n == 4) begin
                checks++;
                if (cpu_ack !== 1'b1) begin
                    errors++; $display("FAIL wr_rom%0b_ack got %b want 1", rom, cpu_ack);
                end
            end else begin
                checks++;
                if (cpu_ack !== 1'b0) begin
                    errors++; $display("FAIL wr_rom%0b_ack_width got %b want 0", rom, cpu_ack);
                end
            end
        end
        checks++;
        if (we_low != (expect_we ? 1 : 0)) begin
            errors++; $display("FAIL wr_rom%0b_we_count got %0d want %0d", rom, we_low, expect_we ? 1 : 0);
        end
        cpu_rom = 0;
    endtask

    task automatic test_contention();
        int exp_seq[6] = '{1, 1, 2, 1, 1, 2};
        int got;
        screen_req = 1; screen_base = 4'h5; screen_addr = 15'h1800;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h12345;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk28);
            if (n <= 18 && (n - 1) % 3 == 0) begin
                got = screen_fetch_allow ? 1 : (!sram_oe_n ? 2 : 0);
                checks++;
                if (got != exp_seq[(n - 1) / 3]) begin
                    errors++;
                    $display("FAIL contention_grant%0d got %0d want %0d (1=scr 2=cpu)",
                             (n - 1) / 3, got, exp_seq[(n - 1) / 3]);
                end
            end
            checks++;
            if (cpu_ack !== (n == 10 || n == 19) || cpu_wait !== !(n == 10 || n == 19)) begin
                errors++;
                $display("FAIL contention_cyc%0d ack=%b wait=%b want %b %b",
                         n, cpu_ack, cpu_wait, (n == 10 || n == 19), !(n == 10 || n == 19));
            end
        end
        screen_req = 0; cpu_req = 0;
        wait_idle("contention");
    endtask

    task automatic test_reset_mid_write();
        cpu_req = 1; cpu_wr = 1; cpu_rom = 0; cpu_addr = 19'h00077; cpu_wdata = 8'h81;
        repeat (2) @(negedge clk28);
        checks++;
        if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre we_n=%b dq_oe=%b want 0 1", sram_we_n, sram_dq_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async we_n=%b dq_oe=%b rdata=%h want 1 0 00", sram_we_n, sram_dq_oe, cpu_rdata);
        end
        cpu_req = 0;
        @(negedge clk28);
        rst_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk28);
            checks++;
            if (cpu_ack !== 1'b0 || sram_we_n !== 1'b1) begin
                errors++; $display("FAIL rstmid_after%0d ack=%b we_n=%b want 0 1", n, cpu_ack, sram_we_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_screen();
        test_cpu_read();
        test_cpu_write(1'b0, 1'b1);
`ifdef MEM_ARBITER_ROM_WP_EN
        test_cpu_write(1'b1, 1'b0);
`else
        test_cpu_write(1'b1, 1'b1);
`endif
        test_contention();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
